// File: rtl/data_mem_pkg.sv
// Shared types, constants and helpers for the multicycle data-memory responder.
package data_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int WORD_WIDTH  = 32;
    localparam int BE_WIDTH    = WORD_WIDTH / 8;
    localparam int LATENCY_MIN = 1;
    localparam int LATENCY_MAX = 15;
    localparam int CNT_WIDTH   = 4;

    // True when the byte address is not word-aligned or lies beyond the array.
    function automatic logic addr_is_bad(input logic [31:0] addr, input int addr_width);
        logic [31:0] high_s;
        high_s = addr >> (addr_width + 2);
        return (addr[1:0] != 2'b00) || (high_s != 32'd0);
    endfunction

    function automatic logic [WORD_WIDTH-1:0] merge_bytes(
        input logic [WORD_WIDTH-1:0] old_word,
        input logic [WORD_WIDTH-1:0] new_word,
        input logic [BE_WIDTH-1:0]   be
    );
        logic [WORD_WIDTH-1:0] merged_s;
        merged_s = old_word;
        for (int b = 0; b < BE_WIDTH; b++) begin
            merged_s[8*b +: 8] = be[b] ? new_word[8*b +: 8] : old_word[8*b +: 8];
        end
        return merged_s;
    endfunction

endpackage

// File: rtl/data_mem_array.sv
// Word array with a synchronous byte-enabled write port and an asynchronous read port.
module data_mem_array
    import data_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [WORD_WIDTH-1:0] wr_data,
    input  logic [BE_WIDTH-1:0]   wr_be,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [WORD_WIDTH-1:0] rd_data
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    // Contents are deliberately not reset: a committed store must survive a reset.
    logic [WORD_WIDTH-1:0] mem_q [DEPTH];

    // Byte-lane store; disabled lanes keep their previous contents.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= merge_bytes(mem_q[wr_addr], wr_data, wr_be);
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/data_mem_responder.sv
// MEM-stage data memory behind valid/ready request and response channels,
// serving one load or store at a time after a fixed LATENCY (1..15).
module data_mem_responder
    import data_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam logic [CNT_WIDTH-1:0] CNT_LOAD = CNT_WIDTH'(LATENCY - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_e                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   write_q, write_d;
    logic [31:0]            addr_q, addr_d;
    logic [WORD_WIDTH-1:0]  wdata_q, wdata_d;
    logic [BE_WIDTH-1:0]    be_q, be_d;
    logic [WORD_WIDTH-1:0]  rdata_q, rdata_d;
    logic                   err_q, err_d;
    logic                   req_ready_q, req_ready_d;
    logic                   resp_valid_q, resp_valid_d;

    logic                   access_err_s;
    logic                   access_now_s;
    logic                   mem_we_s;
    logic                   load_ok_s;
    logic [ADDR_WIDTH-1:0]  word_idx_s;
    logic [WORD_WIDTH-1:0]  rd_data_s;

    assign access_err_s = addr_is_bad(addr_q, ADDR_WIDTH);
    assign access_now_s = (state_q == BUSY) && (cnt_q == CNT_ZERO);
    // The write is gated by the live state, so a reset during BUSY discards the store.
    assign mem_we_s     = access_now_s && write_q && !access_err_s;
    assign load_ok_s    = !write_q && !access_err_s;
    assign word_idx_s   = addr_q[ADDR_WIDTH+1:2];

    data_mem_array #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_array (
        .clk     (clk),
        .wr_en   (mem_we_s),
        .wr_addr (word_idx_s),
        .wr_data (wdata_q),
        .wr_be   (be_q),
        .rd_addr (word_idx_s),
        .rd_data (rd_data_s)
    );

    // Next-state, request latch and response computation.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        rdata_d = rdata_q;
        err_d   = err_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    write_d = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    be_d    = req_be;
                    cnt_d   = CNT_LOAD;
                    state_d = BUSY;
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (cnt_q == CNT_ZERO) begin
                    err_d   = access_err_s;
                    rdata_d = load_ok_s ? rd_data_s : 32'd0;
                    state_d = RESP;
                end else begin
                    cnt_d   = cnt_q - CNT_ONE;
                    state_d = BUSY;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    rdata_d = 32'd0;
                    err_d   = 1'b0;
                    state_d = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                cnt_d   = CNT_ZERO;
                rdata_d = 32'd0;
                err_d   = 1'b0;
                state_d = IDLE;
            end
        endcase

        req_ready_d  = (state_d == IDLE);
        resp_valid_d = (state_d == RESP);
    end

    // State, request latches and registered handshake/response outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= CNT_ZERO;
            write_q      <= 1'b0;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            be_q         <= 4'd0;
            rdata_q      <= 32'd0;
            err_q        <= 1'b0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            write_q      <= write_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            be_q         <= be_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomised and directed bench for data_mem_responder against a word-array reference model,
// with four instances covering LATENCY = 2, 4, 1 and 15.
module tb_data_mem_responder;

    localparam int N_DUT = 4;

    logic              clk   = 1'b0;
    logic              reset = 1'b0;
    logic [N_DUT-1:0]  req_valid, req_ready, req_write;
    logic [N_DUT-1:0]  resp_valid, resp_ready, resp_err;
    logic [31:0]       req_addr   [N_DUT];
    logic [31:0]       req_wdata  [N_DUT];
    logic [3:0]        req_be     [N_DUT];
    logic [31:0]       resp_rdata [N_DUT];

    logic [31:0]       model [N_DUT][256];
    int                n_checks = 0;
    int                n_fails  = 0;
    int                cyc      = 0;

    function automatic int lat_of(input int d);
        case (d)
            0:       return 2;
            1:       return 4;
            2:       return 1;
            default: return 15;
        endcase
    endfunction

    for (genvar g = 0; g < N_DUT; g++) begin : g_dut
        data_mem_responder #(
            .ADDR_WIDTH (8),
            .LATENCY    (lat_of(g))
        ) u_dut (
            .clk        (clk),
            .reset      (reset),
            .req_valid  (req_valid[g]),
            .req_ready  (req_ready[g]),
            .req_write  (req_write[g]),
            .req_addr   (req_addr[g]),
            .req_wdata  (req_wdata[g]),
            .req_be     (req_be[g]),
            .resp_valid (resp_valid[g]),
            .resp_ready (resp_ready[g]),
            .resp_rdata (resp_rdata[g]),
            .resp_err   (resp_err[g])
        );
    end

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: 256 words per instance, byte-granular stores, error on misaligned or >= 1 KiB.
    task automatic model_access(input int d, input logic wr, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [3:0] be,
                                output logic [31:0] rdata, output logic err);
        int idx;
        err   = ((addr % 32'd4) != 32'd0) || (addr >= 32'd1024);
        rdata = 32'd0;
        if (!err) begin
            idx = int'(addr / 32'd4);
            if (wr) begin
                for (int i = 0; i < 4; i++) begin
                    if (be[i]) model[d][idx][8*i +: 8] = wdata[8*i +: 8];
                end
            end else begin
                rdata = model[d][idx];
            end
        end
    endtask

    // Present a request, wait for its accept edge, then scramble the request inputs.
    task automatic issue(input int d, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be);
        int n = 0;
        @(negedge clk);
        req_valid[d] = 1'b1;
        req_write[d] = wr;
        req_addr[d]  = addr;
        req_wdata[d] = wdata;
        req_be[d]    = be;
        while (!req_ready[d] && n < 64) begin
            @(negedge clk);
            n++;
        end
        check("accept_ready", 32'(req_ready[d]), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid[d] = 1'b0;
        req_write[d] = 1'($urandom);
        req_addr[d]  = $urandom;
        req_wdata[d] = $urandom;
        req_be[d]    = 4'($urandom);
        check("accepted", 32'(req_ready[d]), 32'd0);
    endtask

    task automatic wait_valid(input int d, output int n);
        n = 0;
        while (!resp_valid[d] && n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
    endtask

    task automatic txn(input int d, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be, input int stall);
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          n;
        model_access(d, wr, addr, wdata, be, exp_rdata, exp_err);
        issue(d, wr, addr, wdata, be);
        resp_ready[d] = 1'($urandom);
        wait_valid(d, n);
        resp_ready[d] = 1'b0;
        check("latency", 32'(n), 32'(lat_of(d)));
        for (int s = 0; s < stall; s++) begin
            check("stall_rdata", resp_rdata[d], exp_rdata);
            check("stall_req_ready", 32'(req_ready[d]), 32'd0);
            @(posedge clk);
            @(negedge clk);
        end
        check("resp_valid", 32'(resp_valid[d]), 32'd1);
        check("rdata", resp_rdata[d], exp_rdata);
        check("err", 32'(resp_err[d]), 32'(exp_err));
        resp_ready[d] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready[d] = 1'($urandom);
        check("idle_after_hs", 32'(req_ready[d]), 32'd1);
        check("valid_after_hs", 32'(resp_valid[d]), 32'd0);
    endtask

    // Back-to-back loads with requests held and resp_ready high: one accept every LATENCY+2 cycles.
    task automatic burst(input int d, input logic [31:0] addr, input int count);
        int          t_prev = 0;
        int          seen   = 0;
        int          n      = 0;
        logic [31:0] exp;
        exp = model[d][int'(addr / 32'd4)];
        @(negedge clk);
        req_valid[d]  = 1'b1;
        req_write[d]  = 1'b0;
        req_addr[d]   = addr;
        req_be[d]     = 4'($urandom);
        resp_ready[d] = 1'b1;
        while (seen < count && n < 400) begin
            if (req_ready[d]) begin
                if (seen > 0) check("burst_period", 32'(cyc - t_prev), 32'(lat_of(d) + 2));
                t_prev = cyc;
                seen++;
            end
            if (resp_valid[d]) check("burst_rdata", resp_rdata[d], exp);
            @(negedge clk);
            n++;
        end
        check("burst_count", 32'(seen), 32'(count));
        req_valid[d] = 1'b0;
        n = 0;
        while (!req_ready[d] && n < 40) begin
            if (resp_valid[d]) check("burst_rdata", resp_rdata[d], exp);
            @(negedge clk);
            n++;
        end
        check("burst_drain", 32'(req_ready[d]), 32'd1);
        resp_ready[d] = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int d = 0; d < N_DUT; d++) begin
            check({tag, "_req_ready"},  32'(req_ready[d]),  32'd1);
            check({tag, "_resp_valid"}, 32'(resp_valid[d]), 32'd0);
            check({tag, "_resp_rdata"}, resp_rdata[d],      32'd0);
            check({tag, "_resp_err"},   32'(resp_err[d]),   32'd0);
        end
    endtask

    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [31:0] rnd_addr;
    int          nv;

    initial begin
        req_valid  = '0;
        req_write  = '0;
        resp_ready = '0;
        for (int d = 0; d < N_DUT; d++) begin
            req_addr[d]  = 32'd0;
            req_wdata[d] = 32'd0;
            req_be[d]    = 4'd0;
            for (int i = 0; i < 256; i++) model[d][i] = 32'd0;
        end
        #1 reset = 1'b1;
        #2 check_reset_outputs("reset");
        @(negedge clk);
        reset = 1'b0;

        // Known-zero contents for instance 0.
        for (int i = 0; i < 256; i++) txn(0, 1'b1, 32'(i * 4), 32'd0, 4'hF, 0);

        txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
        txn(0, 1'b0, 32'h10, 32'd0,        4'h0, 0);
        txn(0, 1'b1, 32'h20, 32'h11223344, 4'hF, 0);
        txn(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 1);
        txn(0, 1'b0, 32'h20, 32'd0,        4'h0, 0);
        txn(0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, 0);
        txn(0, 1'b0, 32'h20, 32'd0,        4'hF, 2);
        txn(0, 1'b0, 32'h13, 32'd0,        4'hF, 0);
        txn(0, 1'b1, 32'h400, 32'h87654321, 4'hF, 0);
        txn(0, 1'b0, 32'h0,  32'd0,        4'h0, 0);

        // Response backpressure with a second request held on the channel.
        model_access(0, 1'b0, 32'h10, 32'd0, 4'h0, exp_rdata, exp_err);
        issue(0, 1'b0, 32'h10, 32'd0, 4'h0);
        req_valid[0]  = 1'b1;
        req_write[0]  = 1'b1;
        req_addr[0]   = 32'h44;
        req_wdata[0]  = 32'h5A5A0F0F;
        req_be[0]     = 4'hF;
        resp_ready[0] = 1'b0;
        wait_valid(0, nv);
        check("bp_latency", 32'(nv), 32'd2);
        for (int s = 0; s < 5; s++) begin
            check("bp_rdata_stable", resp_rdata[0], exp_rdata);
            check("bp_req_ready_low", 32'(req_ready[0]), 32'd0);
            @(posedge clk);
            @(negedge clk);
        end
        check("bp_valid_held", 32'(resp_valid[0]), 32'd1);
        resp_ready[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready[0] = 1'b0;
        check("bp_ready_after_hs", 32'(req_ready[0]), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid[0] = 1'b0;
        check("bp_second_accepted", 32'(req_ready[0]), 32'd0);
        model_access(0, 1'b1, 32'h44, 32'h5A5A0F0F, 4'hF, exp_rdata, exp_err);
        wait_valid(0, nv);
        check("bp2_latency", 32'(nv), 32'd2);
        check("bp2_rdata", resp_rdata[0], 32'd0);
        check("bp2_err", 32'(resp_err[0]), 32'd0);
        resp_ready[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready[0] = 1'b0;
        txn(0, 1'b0, 32'h44, 32'd0, 4'h0, 0);

        // Randomised traffic over a small window so loads hit earlier stores.
        for (int k = 0; k < 80; k++) begin
            rnd_addr = {22'd0, 8'($urandom_range(0, 15)), 2'b00};
            case ($urandom_range(0, 9))
                0:       rnd_addr[1:0]   = 2'($urandom_range(1, 3));
                1:       rnd_addr[31:10] = 22'($urandom_range(1, 4194303));
                default: rnd_addr        = rnd_addr;
            endcase
            txn(0, 1'($urandom), rnd_addr, $urandom, 4'($urandom), $urandom_range(0, 3));
        end

        // Reset during BUSY discards the store (LATENCY=4).
        txn(1, 1'b1, 32'h30, 32'd0, 4'hF, 0);
        issue(1, 1'b1, 32'h30, 32'hCAFEF00D, 4'hF);
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        #1 check_reset_outputs("busy_reset");
        @(negedge clk);
        reset = 1'b0;
        txn(1, 1'b0, 32'h30, 32'd0, 4'h0, 0);

        // Reset during RESP keeps the committed store.
        txn(1, 1'b1, 32'h34, 32'd0, 4'hF, 0);
        model_access(1, 1'b1, 32'h34, 32'h12345678, 4'hF, exp_rdata, exp_err);
        issue(1, 1'b1, 32'h34, 32'h12345678, 4'hF);
        resp_ready[1] = 1'b0;
        wait_valid(1, nv);
        check("resp_reset_latency", 32'(nv), 32'd4);
        #1 reset = 1'b1;
        #1 check_reset_outputs("resp_reset");
        @(negedge clk);
        reset = 1'b0;
        txn(1, 1'b0, 32'h34, 32'd0, 4'h0, 0);

        // Latency extremes.
        txn(2, 1'b1, 32'h14, 32'hA5A50001, 4'hF, 0);
        burst(2, 32'h14, 4);
        txn(3, 1'b1, 32'h14, 32'h0F0F0003, 4'hF, 1);
        burst(3, 32'h14, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached (t=%0t)", $time);
        $fatal(1, "watchdog");
    end

endmodule
